seq_mult_q: RTL and testbench

//  Parametrised iterative (radix-2 shift-add) fixed-point multiplier for the FIR datapath.

---
 rtl/seq_mult_q_pkg.sv | 19 +
 rtl/seq_mult_q_post.sv | 62 ++++++
 rtl/seq_mult_q.sv | 121 ++++++++++++
 tb/tb_seq_mult_q.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_q_pkg.sv
// Shared types and helpers for the iterative shift-add fixed-point multiplier.
// Holds the controller state encoding and the counter-width function.
package seq_mult_q_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIN,
    DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_q_post.sv
// Post-processing of the full-width product: round, scale by FRAC_BITS, then clamp or wrap.
// Purely combinational; the parent registers its outputs.
module seq_mult_q_post
  import seq_mult_q_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 16,
  parameter int SIGNED    = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 1
) (
  input  logic [2*WIDTH-1:0] p,
  output logic [OUT_W-1:0]   data,
  output logic               ovf
);

  localparam int PW  = 2 * WIDTH;
  // One guard bit above the product keeps the rounding carry; also wide enough to test OUT_W+1 bits.
  localparam int XW  = (PW > OUT_W) ? PW + 1 : OUT_W + 1;
  localparam int RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [XW-1:0] RND =
    ((ROUND != 0) && (FRAC_BITS > 0)) ? (XW'(1) << RSH) : {XW{1'b0}};

  function automatic logic signed [XW-1:0] round_shift(input logic [PW-1:0] prod);
    logic signed [XW-1:0] pe;
    if (SIGNED != 0) pe = {{(XW-PW){prod[PW-1]}}, prod};
    else             pe = {{(XW-PW){1'b0}}, prod};
    return (pe + RND) >>> FRAC_BITS;
  endfunction

  // Returns {ovf, data}; overflow is detected by the bits above the output range.
  function automatic logic [OUT_W:0] saturate(input logic signed [XW-1:0] r);
    logic             hi_ovf;
    logic             lo_ovf;
    logic [OUT_W-1:0] d;
    if (SIGNED != 0) begin
      hi_ovf = !r[XW-1] && (r[XW-2:OUT_W-1] != '0);
      lo_ovf =  r[XW-1] && (r[XW-2:OUT_W-1] != '1);
    end else begin
      hi_ovf = (r[XW-1:OUT_W] != '0);
      lo_ovf = 1'b0;
    end
    d = r[OUT_W-1:0];
    if ((SAT != 0) && hi_ovf) begin
      if (SIGNED != 0) d = {1'b0, {(OUT_W-1){1'b1}}};
      else             d = {OUT_W{1'b1}};
    end else if ((SAT != 0) && lo_ovf) begin
      d = {1'b1, {(OUT_W-1){1'b0}}};
    end
    return {hi_ovf | lo_ovf, d};
  endfunction

  logic [OUT_W:0] res;

  always_comb begin
    res  = saturate(round_shift(p));
    data = res[OUT_W-1:0];
    ovf  = res[OUT_W];
  end

endmodule

// File: rtl/seq_mult_q.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied over WIDTH cycles, the sign is
// re-applied in FIN, and the scaled result is held on a valid/ready output.
module seq_mult_q
  import seq_mult_q_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 16,
  parameter int SIGNED    = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, nstate;

  logic [CW-1:0]           cnt;
  logic [PW-1:0]           mcand_p0;
  logic [WIDTH-1:0]        mplier_p0;
  logic [PW-1:0]           acc_p0;
  logic                    neg_p0;
  logic signed [PW-1:0]    prod_p1;
  logic [OUT_W-1:0]        post_data_p1;
  logic                    post_ovf_p1;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if ((SIGNED != 0) && x[WIDTH-1]) return -x;
    else                             return x;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid) nstate = BUSY;
      BUSY:    if (cnt == LAST) nstate = FIN;
      FIN:     nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Stage p0: operand capture and one shift-add step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      acc_p0    <= '0;
      neg_p0    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand_p0  <= {{WIDTH{1'b0}}, mag(a)};
            mplier_p0 <= mag(b);
            neg_p0    <= (SIGNED != 0) && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_p0    <= '0;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
          mcand_p0  <= mcand_p0 << 1;
          mplier_p0 <= mplier_p0 >> 1;
          cnt       <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: sign re-applied to the magnitude product, then scaled in FIN
  assign prod_p1 = neg_p0 ? -acc_p0 : acc_p0;

  seq_mult_q_post #(
    .WIDTH    (WIDTH),
    .FRAC_BITS(FRAC_BITS),
    .OUT_W    (OUT_W),
    .SIGNED   (SIGNED),
    .ROUND    (ROUND),
    .SAT      (SAT)
  ) u_post (
    .p   (prod_p1),
    .data(post_data_p1),
    .ovf (post_ovf_p1)
  );

  // Stage p2: result register, held from FIN until the next FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      ovf      <= 1'b0;
    end else if (state == FIN) begin
      out_data <= post_data_p1;
      ovf      <= post_ovf_p1;
    end
  end

endmodule

// File: tb/tb_seq_mult_q.sv
// Directed bench: five configurations run in lockstep on shared operands.
// Instances: 0 default, 1 SAT=0, 2 SIGNED, 3 ROUND, 4 SIGNED+ROUND.
module tb_seq_mult_q;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ir [5];
  logic        ov [5];
  logic [15:0] od [5];
  logic        of [5];

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_mult_q u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .ovf(of[0])
  );
  seq_mult_q #(.SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .ovf(of[1])
  );
  seq_mult_q #(.SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .ovf(of[2])
  );
  seq_mult_q #(.ROUND(1)) u_rnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .ovf(of[3])
  );
  seq_mult_q #(.SIGNED(1), .ROUND(1)) u_srnd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]), .a(a), .b(b),
    .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]), .ovf(of[4])
  );

  // Presents one operand pair; lat counts edges from the accepting edge (as 1) through the
  // edge that raises out_valid. Leaves the result pending with out_ready=0.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (ov[0] !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 100) begin
      tests_run++; tests_failed++;
      $display("FAIL timeout: out_valid not seen after %0d edges", lat);
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({ir[i], ov[i], od[i], of[i]} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_state[%0d]: got ir=%b ov=%b od=%h of=%b expected ir=1 ov=0 od=0000 of=0",
                 i, ir[i], ov[i], od[i], of[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(16'h0100, 16'h0280, lat);
    tests_run++;
    if (lat !== 18) begin
      tests_failed++; $display("FAIL unsigned_latency: got %0d expected 18", lat);
    end
    tests_run++;
    if (od[0] !== 16'h0280 || of[0] !== 1'b0) begin
      tests_failed++; $display("FAIL unsigned_data: got %h/%b expected 0280/0", od[0], of[0]);
    end
    tests_run++;
    if (od[1] !== 16'h0280 || of[1] !== 1'b0) begin
      tests_failed++; $display("FAIL unsigned_wrap_cfg: got %h/%b expected 0280/0", od[1], of[1]);
    end
    release_result();
    tests_run++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      tests_failed++; $display("FAIL unsigned_release: got ov=%b ir=%b expected ov=0 ir=1", ov[0], ir[0]);
    end
  endtask

  task automatic test_saturation();
    int lat;
    run_op(16'hFFFF, 16'hFFFF, lat);
    tests_run++;
    if (od[0] !== 16'hFFFF || of[0] !== 1'b1) begin
      tests_failed++; $display("FAIL sat_clamp: got %h/%b expected FFFF/1", od[0], of[0]);
    end
    tests_run++;
    if (od[1] !== 16'hFE00 || of[1] !== 1'b1) begin
      tests_failed++; $display("FAIL sat_wrap: got %h/%b expected FE00/1", od[1], of[1]);
    end
    tests_run++;
    if (od[3] !== 16'hFFFF || of[3] !== 1'b1) begin
      tests_failed++; $display("FAIL sat_round_clamp: got %h/%b expected FFFF/1", od[3], of[3]);
    end
    release_result();
  endtask

  task automatic test_signed();
    int lat;
    run_op(16'hFF00, 16'h0180, lat);
    tests_run++;
    if (od[2] !== 16'hFE80 || of[2] !== 1'b0) begin
      tests_failed++; $display("FAIL signed_neg: got %h/%b expected FE80/0", od[2], of[2]);
    end
    tests_run++;
    if (od[4] !== 16'hFE80 || of[4] !== 1'b0) begin
      tests_failed++; $display("FAIL signed_neg_round: got %h/%b expected FE80/0", od[4], of[4]);
    end
    release_result();
    run_op(16'h8000, 16'h8000, lat);
    tests_run++;
    if (od[2] !== 16'h7FFF || of[2] !== 1'b1) begin
      tests_failed++; $display("FAIL signed_corner: got %h/%b expected 7FFF/1", od[2], of[2]);
    end
    release_result();
  endtask

  task automatic test_rounding();
    int lat;
    run_op(16'h0001, 16'h0080, lat);
    tests_run++;
    if (od[0] !== 16'h0000 || of[0] !== 1'b0) begin
      tests_failed++; $display("FAIL round_floor: got %h/%b expected 0000/0", od[0], of[0]);
    end
    tests_run++;
    if (od[3] !== 16'h0001 || of[3] !== 1'b0) begin
      tests_failed++; $display("FAIL round_half_up: got %h/%b expected 0001/0", od[3], of[3]);
    end
    release_result();
    run_op(16'hFFFF, 16'h0080, lat);
    tests_run++;
    if (od[4] !== 16'h0000 || of[4] !== 1'b0) begin
      tests_failed++; $display("FAIL round_signed_half: got %h/%b expected 0000/0", od[4], of[4]);
    end
    tests_run++;
    if (od[2] !== 16'hFFFF || of[2] !== 1'b0) begin
      tests_failed++; $display("FAIL floor_signed_neg: got %h/%b expected FFFF/0", od[2], of[2]);
    end
    tests_run++;
    if (od[3] !== 16'h8000 || of[3] !== 1'b0) begin
      tests_failed++; $display("FAIL round_unsigned_carry: got %h/%b expected 8000/0", od[3], of[3]);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h0003, 16'h0200, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({ov[0], ir[0], od[0], of[0]} !== {1'b1, 1'b0, 16'h0006, 1'b0}) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b od=%h of=%b expected ov=1 ir=0 od=0006 of=0",
                 i, ov[0], ir[0], od[0], of[0]);
      end
    end
    in_valid = 1'b0;
    release_result();
    tests_run++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      tests_failed++; $display("FAIL backpressure_release: got ov=%b ir=%b expected ov=0 ir=1", ov[0], ir[0]);
    end
    run_op(16'h0100, 16'h0280, lat);
    tests_run++;
    if (od[0] !== 16'h0280 || lat !== 18) begin
      tests_failed++; $display("FAIL backpressure_next: got %h lat=%0d expected 0280 lat=18", od[0], lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    a = 16'h0200; b = 16'h0300; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (ov[0] !== 1'b1 && n < 100) begin
      @(posedge clk); n++; @(negedge clk);
    end
    tests_run++;
    if (od[0] !== 16'h0600 || ov[0] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_first: got %h ov=%b expected 0600 ov=1", od[0], ov[0]);
    end
    a = 16'h0400; b = 16'h0100;
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (ov[0] !== 1'b1 && n < 100);
    tests_run++;
    if (n !== 19) begin
      tests_failed++; $display("FAIL b2b_period: got %0d expected 19", n);
    end
    tests_run++;
    if (od[0] !== 16'h0400) begin
      tests_failed++; $display("FAIL b2b_second: got %h expected 0400", od[0]);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_drain: got ov=%b ir=%b expected ov=0 ir=1", ov[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    a = 16'h0100; b = 16'h0280; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    tests_run++;
    if (ir[0] !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_busy: got ir=%b expected 0", ir[0]);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset_abort: got ov=%b ir=%b od=%h expected ov=0 ir=1 od=0000", ov[0], ir[0], od[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0100, 16'h0280, lat);
    tests_run++;
    if (od[0] !== 16'h0280 || of[0] !== 1'b0 || lat !== 18) begin
      tests_failed++;
      $display("FAIL midreset_rerun: got %h/%b lat=%0d expected 0280/0 lat=18", od[0], of[0], lat);
    end
    release_result();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_unsigned();
    test_saturation();
    test_signed();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
